// File: rtl/axi4_mem_pkg.sv
// Shared definitions for the AXI4 behavioural memory slave: bus widths,
// burst and response codes, FSM state encodings and a byte-strobe merge helper.
package axi4_mem_pkg;

  localparam int unsigned DATA_W = 64;
  localparam int unsigned STRB_W = DATA_W / 8;

  // AXI burst type codes (3 is reserved and handled like INCR)
  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  // AXI response codes
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_DATA = 2'd1,
    W_RESP = 2'd2
  } w_state_e;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } r_state_e;

  // Replace only the byte lanes whose strobe bit is set
  function automatic logic [DATA_W-1:0] strb_merge(
    input logic [DATA_W-1:0] old_word,
    input logic [DATA_W-1:0] new_word,
    input logic [STRB_W-1:0] strb
  );
    logic [DATA_W-1:0] res;
    res = old_word;
    for (int i = 0; i < int'(STRB_W); i++) begin
      if (strb[i]) begin
        res[8*i +: 8] = new_word[8*i +: 8];
      end else begin
        res[8*i +: 8] = old_word[8*i +: 8];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/axi4_burst_addr.sv
// Combinational next-beat address for one AXI channel.
// FIXED keeps the address, INCR adds the transfer size, WRAP adds the size
// but stays inside the aligned block of (len+1)<<size bytes.
module axi4_burst_addr
  import axi4_mem_pkg::*;
(
  input  logic [31:0] addr_i,
  input  logic [2:0]  size_i,
  input  logic [7:0]  len_i,
  input  logic [1:0]  burst_i,
  output logic [31:0] next_addr_o
);

  logic [31:0] step_s;
  logic [31:0] incr_s;
  logic [31:0] blk_s;
  logic [31:0] mask_s;

  assign step_s = 32'd1 << size_i;
  assign incr_s = addr_i + step_s;
  assign blk_s  = ({24'd0, len_i} + 32'd1) << size_i;
  assign mask_s = blk_s - 32'd1;

  // Select the next address according to the burst type
  always_comb begin
    next_addr_o = incr_s;
    case (burst_i)
      BURST_FIXED: next_addr_o = addr_i;
      BURST_INCR:  next_addr_o = incr_s;
      BURST_WRAP:  next_addr_o = (addr_i & ~mask_s) | (incr_s & mask_s);
      default:     next_addr_o = incr_s;
    endcase
  end

endmodule

// File: rtl/axi4_mem_slave.sv
// Behavioural AXI4 slave memory (simulation model of main memory).
// Independent read and write engines, FIXED/INCR/WRAP bursts up to 256 beats,
// byte strobes on writes, SLVERR for beats outside the backing array.
// The backing array starts zeroed at time 0.
module axi4_mem_slave
  import axi4_mem_pkg::*;
#(
  parameter int unsigned MEM_DEPTH = 4096,
  parameter logic [31:0] ADDR_BASE = 32'h8000_0000,
  parameter string       INIT_FILE = "mem.hex"
) (
  input  logic              clock,
  input  logic              rst_n,
  // write address
  input  logic [3:0]        io_slave_awid,
  input  logic [31:0]       io_slave_awaddr,
  input  logic [7:0]        io_slave_awlen,
  input  logic [2:0]        io_slave_awsize,
  input  logic [1:0]        io_slave_awburst,
  input  logic              io_slave_awvalid,
  output logic              io_slave_awready,
  // write data
  input  logic [DATA_W-1:0] io_slave_wdata,
  input  logic [STRB_W-1:0] io_slave_wstrb,
  input  logic              io_slave_wlast,
  input  logic              io_slave_wvalid,
  output logic              io_slave_wready,
  // write response
  output logic [3:0]        io_slave_bid,
  output logic [1:0]        io_slave_bresp,
  output logic              io_slave_bvalid,
  input  logic              io_slave_bready,
  // read address
  input  logic [3:0]        io_slave_arid,
  input  logic [31:0]       io_slave_araddr,
  input  logic [7:0]        io_slave_arlen,
  input  logic [2:0]        io_slave_arsize,
  input  logic [1:0]        io_slave_arburst,
  input  logic              io_slave_arvalid,
  output logic              io_slave_arready,
  // read data
  output logic [3:0]        io_slave_rid,
  output logic [DATA_W-1:0] io_slave_rdata,
  output logic [1:0]        io_slave_rresp,
  output logic              io_slave_rlast,
  output logic              io_slave_rvalid,
  input  logic              io_slave_rready
);

  localparam int unsigned IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

  logic [DATA_W-1:0] mem_q [MEM_DEPTH];

  // The beat counter decides the last beat, so wlast is deliberately ignored
  logic unused_s;
  assign unused_s = io_slave_wlast;

  function automatic logic in_range(input logic [31:0] addr);
    logic [31:0] off;
    off = addr - ADDR_BASE;
    return (addr >= ADDR_BASE) && ((off >> 3) < 32'(MEM_DEPTH));
  endfunction

  function automatic logic [IDX_W-1:0] word_idx(input logic [31:0] addr);
    logic [31:0] off;
    off = addr - ADDR_BASE;
    return IDX_W'(off >> 3);
  endfunction

  // ---------------- write engine state ----------------
  w_state_e    w_state_q, w_state_d;
  logic [3:0]  w_id_q, w_id_d;
  logic [31:0] w_addr_q, w_addr_d;
  logic [7:0]  w_len_q, w_len_d;
  logic [2:0]  w_size_q, w_size_d;
  logic [1:0]  w_burst_q, w_burst_d;
  logic [7:0]  w_cnt_q, w_cnt_d;
  logic        w_err_q, w_err_d;
  logic        awready_q, awready_d;
  logic        wready_q, wready_d;
  logic        bvalid_q, bvalid_d;
  logic [3:0]  bid_q, bid_d;
  logic [1:0]  bresp_q, bresp_d;

  logic [31:0]      w_next_s;
  logic             w_oor_s;
  logic [IDX_W-1:0] w_idx_s;
  logic             mem_we_s;

  // ---------------- read engine state ----------------
  r_state_e          r_state_q, r_state_d;
  logic [31:0]       r_addr_q, r_addr_d;
  logic [7:0]        r_len_q, r_len_d;
  logic [2:0]        r_size_q, r_size_d;
  logic [1:0]        r_burst_q, r_burst_d;
  logic [7:0]        r_cnt_q, r_cnt_d;
  logic              arready_q, arready_d;
  logic              rvalid_q, rvalid_d;
  logic              rlast_q, rlast_d;
  logic [3:0]        rid_q, rid_d;
  logic [1:0]        rresp_q, rresp_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  logic [31:0]       r_next_s;
  logic [31:0]       r_fetch_addr_s;
  logic              r_fetch_oor_s;
  logic [DATA_W-1:0] r_fetch_data_s;

  axi4_burst_addr u_w_addr (
    .addr_i      (w_addr_q),
    .size_i      (w_size_q),
    .len_i       (w_len_q),
    .burst_i     (w_burst_q),
    .next_addr_o (w_next_s)
  );

  axi4_burst_addr u_r_addr (
    .addr_i      (r_addr_q),
    .size_i      (r_size_q),
    .len_i       (r_len_q),
    .burst_i     (r_burst_q),
    .next_addr_o (r_next_s)
  );

  assign w_oor_s = !in_range(w_addr_q);
  assign w_idx_s = word_idx(w_addr_q);

  // Read data for the beat about to be presented: the AR address when idle,
  // the following burst address otherwise. Sampled into rdata_q at the edge,
  // so a write landing on the same edge is not yet visible (old data).
  assign r_fetch_addr_s = (r_state_q == R_IDLE) ? io_slave_araddr : r_next_s;
  assign r_fetch_oor_s  = !in_range(r_fetch_addr_s);
  assign r_fetch_data_s = r_fetch_oor_s ? '0 : mem_q[word_idx(r_fetch_addr_s)];

  assign io_slave_awready = awready_q;
  assign io_slave_wready  = wready_q;
  assign io_slave_bvalid  = bvalid_q;
  assign io_slave_bid     = bid_q;
  assign io_slave_bresp   = bresp_q;
  assign io_slave_arready = arready_q;
  assign io_slave_rvalid  = rvalid_q;
  assign io_slave_rlast   = rlast_q;
  assign io_slave_rid     = rid_q;
  assign io_slave_rresp   = rresp_q;
  assign io_slave_rdata   = rdata_q;

  // Backing store initial contents
  initial begin
    for (int unsigned i = 0; i < MEM_DEPTH; i++) begin
      mem_q[i] = '0;
    end
  end

  // Backing store write port; contents survive reset
  always_ff @(posedge clock) begin
    if (mem_we_s) begin
      mem_q[w_idx_s] <= strb_merge(mem_q[w_idx_s], io_slave_wdata, io_slave_wstrb);
    end
  end

  // Write FSM next-state and output logic
  always_comb begin
    w_state_d = w_state_q;
    w_id_d    = w_id_q;
    w_addr_d  = w_addr_q;
    w_len_d   = w_len_q;
    w_size_d  = w_size_q;
    w_burst_d = w_burst_q;
    w_cnt_d   = w_cnt_q;
    w_err_d   = w_err_q;
    awready_d = awready_q;
    wready_d  = wready_q;
    bvalid_d  = bvalid_q;
    bid_d     = bid_q;
    bresp_d   = bresp_q;
    mem_we_s  = 1'b0;
    case (w_state_q)
      W_IDLE: begin
        awready_d = 1'b1;
        if (io_slave_awvalid && awready_q) begin
          w_id_d    = io_slave_awid;
          w_addr_d  = io_slave_awaddr;
          w_len_d   = io_slave_awlen;
          w_size_d  = io_slave_awsize;
          w_burst_d = io_slave_awburst;
          w_cnt_d   = 8'd0;
          w_err_d   = 1'b0;
          awready_d = 1'b0;
          wready_d  = 1'b1;
          w_state_d = W_DATA;
        end else begin
          w_state_d = W_IDLE;
        end
      end
      W_DATA: begin
        if (io_slave_wvalid && wready_q) begin
          mem_we_s = !w_oor_s;
          w_addr_d = w_next_s;
          w_cnt_d  = w_cnt_q + 8'd1;
          w_err_d  = w_err_q | w_oor_s;
          if (w_cnt_q == w_len_q) begin
            wready_d  = 1'b0;
            bvalid_d  = 1'b1;
            bid_d     = w_id_q;
            bresp_d   = (w_err_q | w_oor_s) ? RESP_SLVERR : RESP_OKAY;
            w_state_d = W_RESP;
          end else begin
            w_state_d = W_DATA;
          end
        end else begin
          w_state_d = W_DATA;
        end
      end
      W_RESP: begin
        if (io_slave_bready && bvalid_q) begin
          bvalid_d  = 1'b0;
          awready_d = 1'b1;
          w_state_d = W_IDLE;
        end else begin
          w_state_d = W_RESP;
        end
      end
      default: begin
        awready_d = 1'b0;
        wready_d  = 1'b0;
        bvalid_d  = 1'b0;
        w_state_d = W_IDLE;
      end
    endcase
  end

  // Write FSM state and registered outputs
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      w_state_q <= W_IDLE;
      w_id_q    <= 4'd0;
      w_addr_q  <= 32'd0;
      w_len_q   <= 8'd0;
      w_size_q  <= 3'd0;
      w_burst_q <= 2'd0;
      w_cnt_q   <= 8'd0;
      w_err_q   <= 1'b0;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bid_q     <= 4'd0;
      bresp_q   <= 2'd0;
    end else begin
      w_state_q <= w_state_d;
      w_id_q    <= w_id_d;
      w_addr_q  <= w_addr_d;
      w_len_q   <= w_len_d;
      w_size_q  <= w_size_d;
      w_burst_q <= w_burst_d;
      w_cnt_q   <= w_cnt_d;
      w_err_q   <= w_err_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      bvalid_q  <= bvalid_d;
      bid_q     <= bid_d;
      bresp_q   <= bresp_d;
    end
  end

  // Read FSM next-state and output logic
  always_comb begin
    r_state_d = r_state_q;
    r_addr_d  = r_addr_q;
    r_len_d   = r_len_q;
    r_size_d  = r_size_q;
    r_burst_d = r_burst_q;
    r_cnt_d   = r_cnt_q;
    arready_d = arready_q;
    rvalid_d  = rvalid_q;
    rlast_d   = rlast_q;
    rid_d     = rid_q;
    rresp_d   = rresp_q;
    rdata_d   = rdata_q;
    case (r_state_q)
      R_IDLE: begin
        arready_d = 1'b1;
        if (io_slave_arvalid && arready_q) begin
          rid_d     = io_slave_arid;
          r_addr_d  = io_slave_araddr;
          r_len_d   = io_slave_arlen;
          r_size_d  = io_slave_arsize;
          r_burst_d = io_slave_arburst;
          r_cnt_d   = 8'd0;
          rdata_d   = r_fetch_data_s;
          rresp_d   = r_fetch_oor_s ? RESP_SLVERR : RESP_OKAY;
          rlast_d   = (io_slave_arlen == 8'd0);
          rvalid_d  = 1'b1;
          arready_d = 1'b0;
          r_state_d = R_DATA;
        end else begin
          r_state_d = R_IDLE;
        end
      end
      R_DATA: begin
        if (io_slave_rready && rvalid_q) begin
          if (r_cnt_q == r_len_q) begin
            rvalid_d  = 1'b0;
            rlast_d   = 1'b0;
            arready_d = 1'b1;
            r_state_d = R_IDLE;
          end else begin
            r_addr_d  = r_next_s;
            r_cnt_d   = r_cnt_q + 8'd1;
            rdata_d   = r_fetch_data_s;
            rresp_d   = r_fetch_oor_s ? RESP_SLVERR : RESP_OKAY;
            rlast_d   = ((r_cnt_q + 8'd1) == r_len_q);
            r_state_d = R_DATA;
          end
        end else begin
          r_state_d = R_DATA;
        end
      end
      default: begin
        arready_d = 1'b0;
        rvalid_d  = 1'b0;
        rlast_d   = 1'b0;
        r_state_d = R_IDLE;
      end
    endcase
  end

  // Read FSM state and registered outputs
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      r_state_q <= R_IDLE;
      r_addr_q  <= 32'd0;
      r_len_q   <= 8'd0;
      r_size_q  <= 3'd0;
      r_burst_q <= 2'd0;
      r_cnt_q   <= 8'd0;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rlast_q   <= 1'b0;
      rid_q     <= 4'd0;
      rresp_q   <= 2'd0;
      rdata_q   <= '0;
    end else begin
      r_state_q <= r_state_d;
      r_addr_q  <= r_addr_d;
      r_len_q   <= r_len_d;
      r_size_q  <= r_size_d;
      r_burst_q <= r_burst_d;
      r_cnt_q   <= r_cnt_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rlast_q   <= rlast_d;
      rid_q     <= rid_d;
      rresp_q   <= rresp_d;
      rdata_q   <= rdata_d;
    end
  end

endmodule

// File: tb/tb_axi4_mem_slave.sv
// Directed self-checking bench for axi4_mem_slave.
// Inputs change and outputs are sampled 1ns after each rising clock edge.
module tb_axi4_mem_slave;
  import axi4_mem_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  awid;   logic [31:0] awaddr; logic [7:0] awlen; logic [2:0] awsize;
  logic [1:0]  awburst; logic awvalid; logic awready;
  logic [63:0] wdata;  logic [7:0] wstrb; logic wlast; logic wvalid; logic wready;
  logic [3:0]  bid;    logic [1:0] bresp; logic bvalid; logic bready;
  logic [3:0]  arid;   logic [31:0] araddr; logic [7:0] arlen; logic [2:0] arsize;
  logic [1:0]  arburst; logic arvalid; logic arready;
  logic [3:0]  rid;    logic [63:0] rdata; logic [1:0] rresp; logic rlast; logic rvalid; logic rready;

  int total = 0;
  int bad   = 0;

  logic [63:0] wbuf    [16];
  logic [63:0] rd_data [16];
  logic [1:0]  rd_resp [16];
  logic        rd_last [16];
  logic [3:0]  got_bid, got_rid;
  logic [1:0]  got_bresp;

  axi4_mem_slave dut (
    .clock(clk), .rst_n(rst_n),
    .io_slave_awid(awid), .io_slave_awaddr(awaddr), .io_slave_awlen(awlen),
    .io_slave_awsize(awsize), .io_slave_awburst(awburst),
    .io_slave_awvalid(awvalid), .io_slave_awready(awready),
    .io_slave_wdata(wdata), .io_slave_wstrb(wstrb), .io_slave_wlast(wlast),
    .io_slave_wvalid(wvalid), .io_slave_wready(wready),
    .io_slave_bid(bid), .io_slave_bresp(bresp), .io_slave_bvalid(bvalid),
    .io_slave_bready(bready),
    .io_slave_arid(arid), .io_slave_araddr(araddr), .io_slave_arlen(arlen),
    .io_slave_arsize(arsize), .io_slave_arburst(arburst),
    .io_slave_arvalid(arvalid), .io_slave_arready(arready),
    .io_slave_rid(rid), .io_slave_rdata(rdata), .io_slave_rresp(rresp),
    .io_slave_rlast(rlast), .io_slave_rvalid(rvalid), .io_slave_rready(rready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic sig_of(input int which);
    case (which)
      0: return awready;
      1: return wready;
      2: return bvalid;
      3: return arready;
      4: return rvalid;
      default: return 1'b0;
    endcase
  endfunction

  // wait (bounded) until the selected handshake signal is high
  task automatic wait_hi(input int which, input string tag);
    int n = 0;
    while (sig_of(which) !== 1'b1 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk(tag, 64'(n < 20), 64'd1);
  endtask

  task automatic do_write(input logic [3:0] id, input logic [31:0] addr,
                          input logic [7:0] len, input logic [1:0] burst,
                          input logic [7:0] strb);
    awid = id; awaddr = addr; awlen = len; awsize = 3'd3; awburst = burst;
    awvalid = 1'b1;
    wait_hi(0, "aw_wait");
    @(posedge clk); #1;
    awvalid = 1'b0;
    for (int i = 0; i <= int'(len); i++) begin
      wdata = wbuf[i]; wstrb = strb; wlast = (i == int'(len)); wvalid = 1'b1;
      wait_hi(1, "w_wait");
      @(posedge clk); #1;
    end
    wvalid = 1'b0; wlast = 1'b0;
    bready = 1'b1;
    wait_hi(2, "b_wait");
    got_bid = bid; got_bresp = bresp;
    @(posedge clk); #1;
    bready = 1'b0;
  endtask

  task automatic do_read(input logic [3:0] id, input logic [31:0] addr,
                         input logic [7:0] len, input logic [1:0] burst);
    arid = id; araddr = addr; arlen = len; arsize = 3'd3; arburst = burst;
    arvalid = 1'b1;
    wait_hi(3, "ar_wait");
    @(posedge clk); #1;
    arvalid = 1'b0;
    rready = 1'b1;
    for (int i = 0; i <= int'(len); i++) begin
      wait_hi(4, "r_wait");
      rd_data[i] = rdata; rd_resp[i] = rresp; rd_last[i] = rlast; got_rid = rid;
      @(posedge clk); #1;
    end
    rready = 1'b0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    awid = 4'd0; awaddr = 32'd0; awlen = 8'd0; awsize = 3'd0; awburst = 2'd0; awvalid = 1'b0;
    wdata = 64'd0; wstrb = 8'd0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
    arid = 4'd0; araddr = 32'd0; arlen = 8'd0; arsize = 3'd0; arburst = 2'd0; arvalid = 1'b0;
    rready = 1'b0;
    for (int i = 0; i < 16; i++) wbuf[i] = 64'd0;

    // reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_awready", 64'(awready), 64'd0);
    chk("rst_arready", 64'(arready), 64'd0);
    chk("rst_valids", {60'd0, wready, bvalid, rvalid, rlast}, 64'd0);
    chk("rst_ids", {56'd0, rid, bid}, 64'd0);
    chk("rst_rdata", rdata, 64'd0);
    chk("rst_resps", {60'd0, rresp, bresp}, 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("idle_awready", 64'(awready), 64'd1);
    chk("idle_arready", 64'(arready), 64'd1);

    // single full-strobe write then single read
    wbuf[0] = 64'h1122_3344_5566_7788;
    do_write(4'd3, 32'h8000_0000, 8'd0, BURST_INCR, 8'hFF);
    chk("single_bid", 64'(got_bid), 64'd3);
    chk("single_bresp", 64'(got_bresp), 64'd0);
    do_read(4'd5, 32'h8000_0000, 8'd0, BURST_INCR);
    chk("single_rdata", rd_data[0], 64'h1122_3344_5566_7788);
    chk("single_rresp", 64'(rd_resp[0]), 64'd0);
    chk("single_rlast", 64'(rd_last[0]), 64'd1);
    chk("single_rid", 64'(got_rid), 64'd5);

    // partial strobe onto a zero word
    wbuf[0] = 64'd0;
    do_write(4'd1, 32'h8000_0008, 8'd0, BURST_INCR, 8'hFF);
    wbuf[0] = 64'hAAAA_AAAA_AAAA_AAAA;
    do_write(4'd1, 32'h8000_0008, 8'd0, BURST_INCR, 8'h0F);
    do_read(4'd1, 32'h8000_0008, 8'd0, BURST_INCR);
    chk("strobe_rdata", rd_data[0], 64'h0000_0000_AAAA_AAAA);

    // INCR burst write and read back
    for (int i = 0; i < 4; i++) wbuf[i] = 64'(i);
    do_write(4'd7, 32'h8000_0010, 8'd3, BURST_INCR, 8'hFF);
    chk("incr_bresp", 64'(got_bresp), 64'd0);
    chk("incr_bid", 64'(got_bid), 64'd7);
    do_read(4'd2, 32'h8000_0010, 8'd3, BURST_INCR);
    chk("incr_rd0", rd_data[0], 64'd0);
    chk("incr_rd1", rd_data[1], 64'd1);
    chk("incr_rd2", rd_data[2], 64'd2);
    chk("incr_rd3", rd_data[3], 64'd3);
    chk("incr_rlast", {60'd0, rd_last[0], rd_last[1], rd_last[2], rd_last[3]}, 64'h1);

    // WRAP read inside the 32-byte block 0x20..0x3F
    wbuf[0] = 64'h30; wbuf[1] = 64'h38;
    do_write(4'd0, 32'h8000_0030, 8'd1, BURST_INCR, 8'hFF);
    do_read(4'd4, 32'h8000_0028, 8'd3, BURST_WRAP);
    chk("wrap_rd0", rd_data[0], 64'd3);
    chk("wrap_rd1", rd_data[1], 64'h30);
    chk("wrap_rd2", rd_data[2], 64'h38);
    chk("wrap_rd3", rd_data[3], 64'd2);

    // FIXED burst: both beats hit one word
    wbuf[0] = 64'hA; wbuf[1] = 64'hB;
    do_write(4'd0, 32'h8000_0040, 8'd1, BURST_FIXED, 8'hFF);
    do_read(4'd0, 32'h8000_0040, 8'd1, BURST_FIXED);
    chk("fixed_rd0", rd_data[0], 64'hB);
    chk("fixed_rd1", rd_data[1], 64'hB);
    chk("fixed_rlast", {62'd0, rd_last[0], rd_last[1]}, 64'h1);

    // out-of-range accesses
    do_read(4'd6, 32'h7FFF_FFF8, 8'd0, BURST_INCR);
    chk("oor_rdata", rd_data[0], 64'd0);
    chk("oor_rresp", 64'(rd_resp[0]), 64'h2);
    wbuf[0] = 64'hBAD0;
    do_write(4'd9, 32'h8000_8000, 8'd0, BURST_INCR, 8'hFF);
    chk("oor_bresp", 64'(got_bresp), 64'h2);
    do_read(4'd0, 32'h8000_0000, 8'd0, BURST_INCR);
    chk("oor_mem_kept", rd_data[0], 64'h1122_3344_5566_7788);
    do_read(4'd0, 32'h8000_7FF8, 8'd1, BURST_INCR);
    chk("edge_rresp0", 64'(rd_resp[0]), 64'h0);
    chk("edge_rresp1", 64'(rd_resp[1]), 64'h2);
    wbuf[0] = 64'h1; wbuf[1] = 64'h2;
    do_write(4'd0, 32'h8000_7FF8, 8'd1, BURST_INCR, 8'hFF);
    chk("edge_bresp_sticky", 64'(got_bresp), 64'h2);

    // rready stalled mid-burst
    arid = 4'd8; araddr = 32'h8000_0010; arlen = 8'd3; arsize = 3'd3; arburst = BURST_INCR;
    arvalid = 1'b1;
    wait_hi(3, "stall_ar_wait");
    @(posedge clk); #1;
    arvalid = 1'b0;
    chk("stall_rvalid_n1", 64'(rvalid), 64'd1);
    rready = 1'b1;
    @(posedge clk); #1;
    rready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("stall_rdata", rdata, 64'd1);
      chk("stall_rlast", {62'd0, rvalid, rlast}, 64'h2);
      @(posedge clk); #1;
    end
    rready = 1'b1;
    for (int i = 1; i < 4; i++) begin
      wait_hi(4, "stall_r_wait");
      chk("stall_beat", {rdata[62:0], rlast}, {63'(i), 1'(i == 3)});
      @(posedge clk); #1;
    end
    rready = 1'b0;
    chk("stall_done_rvalid", 64'(rvalid), 64'd0);
    chk("stall_done_arready", 64'(arready), 64'd1);

    // same-edge write and read of one word: read sees old data
    wbuf[0] = 64'h6060_6060;
    do_write(4'd0, 32'h8000_0060, 8'd0, BURST_INCR, 8'hFF);
    awid = 4'd1; awaddr = 32'h8000_0060; awlen = 8'd0; awsize = 3'd3; awburst = BURST_INCR;
    awvalid = 1'b1;
    wait_hi(0, "sc_aw_wait");
    @(posedge clk); #1;
    awvalid = 1'b0;
    chk("sc_wready_n1", 64'(wready), 64'd1);
    wdata = 64'hDEAD_BEEF_0000_0001; wstrb = 8'hFF; wlast = 1'b1; wvalid = 1'b1;
    arid = 4'd2; araddr = 32'h8000_0060; arlen = 8'd0; arburst = BURST_INCR; arvalid = 1'b1;
    @(posedge clk); #1;
    wvalid = 1'b0; wlast = 1'b0; arvalid = 1'b0;
    chk("sc_rvalid", 64'(rvalid), 64'd1);
    chk("sc_old_data", rdata, 64'h6060_6060);
    chk("sc_bvalid", 64'(bvalid), 64'd1);
    rready = 1'b1; bready = 1'b1;
    @(posedge clk); #1;
    rready = 1'b0; bready = 1'b0;
    chk("sc_done", {60'd0, rvalid, bvalid, awready, arready}, 64'h3);
    do_read(4'd0, 32'h8000_0060, 8'd0, BURST_INCR);
    chk("sc_new_data", rd_data[0], 64'hDEAD_BEEF_0000_0001);

    // AW and AR accepted on the same edge
    awaddr = 32'h8000_0070; awid = 4'd3; awlen = 8'd0; awvalid = 1'b1;
    araddr = 32'h8000_0000; arid = 4'd4; arlen = 8'd0; arvalid = 1'b1;
    @(posedge clk); #1;
    awvalid = 1'b0; arvalid = 1'b0;
    chk("dual_accept", {62'd0, wready, rvalid}, 64'h3);
    chk("dual_rdata", rdata, 64'h1122_3344_5566_7788);
    wdata = 64'h7070; wstrb = 8'hFF; wlast = 1'b1; wvalid = 1'b1; rready = 1'b1;
    @(posedge clk); #1;
    wvalid = 1'b0; wlast = 1'b0; rready = 1'b0;
    chk("dual_bid", {59'd0, bvalid, bid}, {59'd1, 4'd3});
    bready = 1'b1;
    @(posedge clk); #1;
    bready = 1'b0;

    // reset pulsed mid-write: burst abandoned, no response
    wbuf[0] = 64'd0;
    awid = 4'd5; awaddr = 32'h8000_0050; awlen = 8'd3; awburst = BURST_INCR; awvalid = 1'b1;
    wait_hi(0, "rst_aw_wait");
    @(posedge clk); #1;
    awvalid = 1'b0;
    wdata = 64'h5050; wstrb = 8'hFF; wvalid = 1'b1;
    wait_hi(1, "rst_w_wait");
    @(posedge clk); #1;
    wvalid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("midrst_outputs", {61'd0, awready, wready, bvalid}, 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("midrst_awready", 64'(awready), 64'd1);
    chk("midrst_wready", 64'(wready), 64'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("midrst_no_bvalid", 64'(bvalid), 64'd0);
    do_read(4'd0, 32'h8000_0050, 8'd0, BURST_INCR);
    chk("midrst_mem_kept", rd_data[0], 64'h5050);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
